acc_alu_regfile: RTL and testbench
==================================

Name: acc_alu_regfile

Overview:
- Parametrised accumulator/ALU engine; next generation of the team's 8-bit adder-accumulator.
- Generalised width, an N-entry operand register file, logic ops, carry-chained add/sub for multi-word arithmetic, and a full C/Z/N/V flag set.
- Commands enter over a valid/ready handshake; results leave over a valid/ready response channel.
- Sits between the chip-top pin mux and user I/O; the top drives cmd_* from ui_in/uio_in and shows acc/flags on outputs.

Parameters:
- WIDTH, 8, datapath width in bits (>=4).
- NREGS, 4, number of operand registers (>=2).
- RS_W, $clog2(NREGS), register-select width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  4  opcode (see Behaviour).
- cmd_rs  in  RS_W  operand register index.
- cmd_data  in  WIDTH  immediate data.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_err  out  1  illegal opcode or rs >= NREGS for the current response.
- acc  out  WIDTH  accumulator value, continuously visible.
- flags  out  4  {V,N,Z,C}.

Behaviour:
- Reset (async, any state): FSM=IDLE; acc=0; all regs=0; flags=0; rsp_valid=0; rsp_err=0; cmd_ready=0 during reset, 1 in the first cycle after release.
- FSM:
  - IDLE: cmd_ready=1. cmd_valid&cmd_ready latches op/rs/data and moves to EXEC.
  - EXEC: cmd_ready=0. Computes the result and updates acc/reg/flags at the end of the cycle, then goes to RESP.
  - RESP: rsp_valid=1. Returns to IDLE on the cycle rsp_ready=1.
- Latency: command accept edge to rsp_valid high is 2 cycles. Maximum throughput is 1 command per 3 cycles.
- rsp_valid, rsp_err, acc and flags stay stable throughout RESP.
- Opcodes:
  - 0 NOP
  - 1 LDA: acc=data
  - 2 LDR: reg[rs]=data
  - 3 STA: reg[rs]=acc
  - 4 ADD: acc=acc+reg[rs]
  - 5 ADC: acc=acc+reg[rs]+C
  - 6 SUB: acc=acc-reg[rs]
  - 7 SBC: acc=acc-reg[rs]-!C (C is the not-borrow convention)
  - 8 AND, 9 OR, 10 XOR: acc=acc op reg[rs]
  - 11 CLR: acc=0, flags=0
  - 12-15: illegal
- Arithmetic is computed at WIDTH+1 bits.
  - C = bit WIDTH of the sum. For SUB/SBC: C=1 means no borrow.
  - V = signed overflow: operands of equal sign (after inverting the subtrahend) give a result of differing sign.
  - Z = (acc_new==0); N = acc_new[WIDTH-1].
- Flag update rules:
  - LDA, AND, OR, XOR update Z and N, clear V, and leave C unchanged.
  - LDR, STA, NOP leave all flags unchanged.
- Error path:
  - Illegal opcode: no state change, rsp_err=1.
  - rs >= NREGS on any rs-using op (only possible when NREGS is not a power of two): no state change, rsp_err=1.
  - The response is still produced, and rsp_err clears on the next accepted command.
- Wrap-around: results are modulo 2^WIDTH, e.g. 0xFF+0x01 gives acc=0x00, C=1, Z=1.
- Simultaneous events: cmd_valid during EXEC/RESP is ignored and not accepted. The command must be held until cmd_ready=1.
- Reset mid-EXEC or mid-RESP: the in-flight command is discarded and no partial register write occurs.
- Register reads in EXEC see the values committed by previous commands. There is no bypass hazard because commands are serialised.

Decomposition:
- Shared package acc_alu_pkg holds:
  - the opcode enum (OP_NOP..OP_CLR);
  - flag bit indices FLG_C=0, FLG_Z=1, FLG_N=2, FLG_V=3;
  - the FSM state enum (S_IDLE, S_EXEC, S_RESP).
- One sub-module, acc_alu_slice: purely combinational, parametrised WIDTH. Inputs are op, a, b, cin; outputs are result and the C/V flags. The top instantiates it once; the FSM, register file and flag register live in the top.

Test Plan (WIDTH=8, NREGS=4):
- Reset release, then LDA 0x5A -> rsp_valid 2 cycles after accept, acc=0x5A, flags Z=0 N=0, rsp_err=0.
- LDR r1=0x01; LDA 0xFF; ADD r1 -> acc=0x00, C=1, Z=1, V=0. Follow with ADC r1 (r1=0x01) -> acc=0x02, C=0.
- LDR r2=0x01; LDA 0x80; SUB r2 -> acc=0x7F, V=1, C=1, N=0. Then LDA 0x00; SBC r2 with C=1 -> acc=0xFF, C=0, N=1.
- Opcode 13 -> rsp_err=1, acc/flags/regs unchanged. Next LDA 0x11 -> rsp_err=0.
- Hold rsp_ready=0 for 5 cycles in RESP while pulsing cmd_valid -> cmd_ready=0, no new command accepted, outputs stable. Raise rsp_ready -> IDLE next cycle.
- Assert rst_n=0 mid-EXEC of a STA r3 -> all outputs return to reset values immediately; r3 still 0 when read back via LDA 0; ADD r3 -> acc=0x00, Z=1.

Source files
------------

// File: rtl/acc_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_alu_pkg
//  Description : Shared opcode/state encodings and flag bit indices for the
//                accumulator/ALU engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_alu_pkg;

    // Command opcodes; encodings 12-15 are illegal and reported via rsp_err
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDA = 4'd1,
        OP_LDR = 4'd2,
        OP_STA = 4'd3,
        OP_ADD = 4'd4,
        OP_ADC = 4'd5,
        OP_SUB = 4'd6,
        OP_SBC = 4'd7,
        OP_AND = 4'd8,
        OP_OR  = 4'd9,
        OP_XOR = 4'd10,
        OP_CLR = 4'd11
    } op_e;

    localparam logic [3:0] C_OP_LAST = 4'd11;

    // Bit positions inside the {V,N,Z,C} flag vector
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    // Command sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Opcodes that index the register file and therefore need a valid rs
    function automatic logic uses_rs(input op_e op);
        return (op inside {OP_LDR, OP_STA, OP_ADD, OP_ADC, OP_SUB, OP_SBC,
                           OP_AND, OP_OR, OP_XOR});
    endfunction

endpackage : acc_alu_pkg
`default_nettype wire

// File: rtl/acc_alu_slice.sv
`default_nettype none
// ============================================================================
//  Module      : acc_alu_slice
//  Description : Combinational ALU datapath. Add/sub share one WIDTH+1 bit
//                adder; subtraction adds the inverted operand so carry-out
//                means "no borrow".
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_alu_slice
    import acc_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_result,
    output logic             o_c,
    output logic             o_v
);

    logic [WIDTH-1:0] w_bb;
    logic             w_ci;
    logic [WIDTH:0]   w_sum;
    logic             w_sub;

    // Operand conditioning and carry-in selection for the shared adder
    always_comb begin
        w_sub = (i_op == OP_SUB) || (i_op == OP_SBC);
        w_bb  = w_sub ? ~i_b : i_b;
        case (i_op)
            OP_ADC, OP_SBC: w_ci = i_cin;
            OP_SUB:         w_ci = 1'b1;
            default:        w_ci = 1'b0;
        endcase
        w_sum = {1'b0, i_a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_ci};
    end

    // Result and carry/overflow selection per opcode
    always_comb begin
        o_result = i_a;
        o_c      = i_cin;
        o_v      = 1'b0;
        case (i_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                o_result = w_sum[WIDTH-1:0];
                o_c      = w_sum[WIDTH];
                o_v      = (i_a[WIDTH-1] == w_bb[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_LDA:  o_result = i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_CLR: begin
                o_result = '0;
                o_c      = 1'b0;
            end
            default: o_result = i_a;
        endcase
    end

endmodule : acc_alu_slice
`default_nettype wire

// File: rtl/acc_alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : acc_alu_regfile
//  Description : Accumulator/ALU engine with operand register file, C/Z/N/V
//                flags and valid/ready command and response channels.
//                Commands are serialised IDLE -> EXEC -> RESP.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_alu_regfile
    import acc_alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int RS_W  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [RS_W-1:0]  cmd_rs,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_err,
    output logic [WIDTH-1:0] acc,
    output logic [3:0]       flags
);

    state_e           r_state;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [3:0]       r_op;
    logic [RS_W-1:0]  r_rs;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_acc;
    logic [3:0]       r_flags;
    logic [WIDTH-1:0] r_regs [NREGS];

    op_e              w_op;
    logic             w_rs_in;
    logic             w_ok;
    logic [WIDTH-1:0] w_rd;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic             w_zero;

    // Decode the latched command and fetch the register operand
    always_comb begin
        w_op    = op_e'(r_op);
        w_rs_in = (int'(r_rs) < NREGS);
        w_ok    = (r_op <= C_OP_LAST) && (!uses_rs(w_op) || w_rs_in);
        w_rd    = w_rs_in ? r_regs[r_rs] : '0;
        w_b     = (w_op == OP_LDA) ? r_data : w_rd;
        w_zero  = (w_res == '0);
    end

    acc_alu_slice #(
        .WIDTH (WIDTH)
    ) u_slice (
        .i_op     (w_op),
        .i_a      (r_acc),
        .i_b      (w_b),
        .i_cin    (r_flags[FLG_C]),
        .o_result (w_res),
        .o_c      (w_c),
        .o_v      (w_v)
    );

    // Command sequencer with architectural state commit at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_op        <= 4'd0;
            r_rs        <= '0;
            r_data      <= '0;
            r_acc       <= '0;
            r_flags     <= 4'd0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_op        <= cmd_op;
                        r_rs        <= cmd_rs;
                        r_data      <= cmd_data;
                        r_rsp_err   <= 1'b0;
                        r_cmd_ready <= 1'b0;
                        r_state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= !w_ok;
                    if (w_ok) begin
                        case (w_op)
                            OP_LDA, OP_AND, OP_OR, OP_XOR: begin
                                r_acc          <= w_res;
                                r_flags[FLG_Z] <= w_zero;
                                r_flags[FLG_N] <= w_res[WIDTH-1];
                                r_flags[FLG_V] <= 1'b0;
                            end
                            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                                r_acc          <= w_res;
                                r_flags[FLG_C] <= w_c;
                                r_flags[FLG_Z] <= w_zero;
                                r_flags[FLG_N] <= w_res[WIDTH-1];
                                r_flags[FLG_V] <= w_v;
                            end
                            OP_LDR:  r_regs[r_rs] <= r_data;
                            OP_STA:  r_regs[r_rs] <= r_acc;
                            OP_CLR: begin
                                r_acc   <= '0;
                                r_flags <= 4'd0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign acc       = r_acc;
    assign flags     = r_flags;

endmodule : acc_alu_regfile
`default_nettype wire

// File: tb/tb_acc_alu_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_alu_regfile
//  Description : Self-checking bench for acc_alu_regfile (WIDTH=8, NREGS=4):
//                directed scenarios with literal expectations, then random
//                commands against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_alu_regfile;

    localparam int W  = 8;
    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [1:0] cmd_rs = 2'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_err;
    logic [7:0] acc;
    logic [3:0] flags;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: accumulator, {V,N,Z,C}, register file, error
    int         m_acc;
    logic [3:0] m_flags;
    int         m_regs [NR];
    logic       m_err;
    logic       cmp_en = 1'b0;
    logic       got_err;

    acc_alu_regfile #(
        .WIDTH (W),
        .NREGS (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_err   (rsp_err),
        .acc       (acc),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_flags = 4'd0;
        m_err   = 1'b0;
        for (int i = 0; i < NR; i++) m_regs[i] = 0;
    endtask

    function automatic int to_signed(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // Apply one command to the model using plain integer arithmetic
    task automatic model_apply(input int op, input int rs, input int data);
        int a, b, cin, r, sr, br;
        a     = m_acc;
        cin   = int'(m_flags[0]);
        m_err = 1'b0;
        if (op > 11) begin
            m_err = 1'b1;
            return;
        end
        b = m_regs[rs];
        case (op)
            1, 8, 9, 10: begin
                if (op == 1)      r = data;
                else if (op == 8) r = a & b;
                else if (op == 9) r = a | b;
                else              r = a ^ b;
                m_acc   = r;
                m_flags = {1'b0, r >= 128, r == 0, m_flags[0]};
            end
            2: m_regs[rs] = data;
            3: m_regs[rs] = m_acc;
            4, 5: begin
                br = (op == 5) ? cin : 0;
                r  = a + b + br;
                sr = to_signed(a) + to_signed(b) + br;
                m_acc   = r % 256;
                m_flags = {(sr > 127) || (sr < -128), m_acc >= 128, m_acc == 0, r > 255};
            end
            6, 7: begin
                br = (op == 7) ? 1 - cin : 0;
                r  = a - b - br;
                sr = to_signed(a) - to_signed(b) - br;
                m_acc   = (r + 512) % 256;
                m_flags = {(sr > 127) || (sr < -128), m_acc >= 128, m_acc == 0, r >= 0};
            end
            11: begin
                m_acc   = 0;
                m_flags = 4'd0;
            end
            default: ;
        endcase
    endtask

    // Every cycle with a response on offer, outputs must match the model
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            if (rsp_valid) begin
                chk("rsp_acc", 32'(acc), 32'(m_acc));
                chk("rsp_flags", 32'(flags), 32'(m_flags));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            chk("ready_excl_valid", 32'(cmd_ready & rsp_valid), 32'd0);
        end
    end

    // Issue one command, check handshake timing, hold the response 'hold' cycles
    task automatic do_cmd(input int op, input int rs, input int data, input int hold, input bit pulse);
        int n;
        n = 0;
        cmd_op    = op[3:0];
        cmd_rs    = rs[1:0];
        cmd_data  = data[7:0];
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_apply(op, rs, data);
        chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
        chk("exec_not_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
        got_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 4'($urandom_range(1, 11));
                cmd_rs    = 2'($urandom_range(0, 3));
                cmd_data  = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_not_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("release_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_acc", 32'(acc), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(cmd_ready), 32'd1);
        cmp_en = 1'b1;

        // LDA 0x5A
        do_cmd(1, 0, 8'h5A, 0, 0);
        chk("lda_acc", 32'(acc), 32'h5A);
        chk("lda_flags", 32'(flags), 32'h0);
        chk("lda_err", 32'(got_err), 32'd0);

        // 0xFF + 0x01 wraps to zero with carry, then ADC consumes it
        do_cmd(2, 1, 8'h01, 0, 0);
        do_cmd(1, 0, 8'hFF, 0, 0);
        do_cmd(4, 1, 0, 0, 0);
        chk("add_wrap_acc", 32'(acc), 32'h00);
        chk("add_wrap_flags", 32'(flags), 32'b0011);
        do_cmd(5, 1, 0, 0, 0);
        chk("adc_acc", 32'(acc), 32'h02);
        chk("adc_flags", 32'(flags), 32'b0000);

        // 0x80 - 1 overflows signed, then SBC with C=1 borrows out of zero
        do_cmd(2, 2, 8'h01, 0, 0);
        do_cmd(1, 0, 8'h80, 0, 0);
        chk("lda80_flags", 32'(flags), 32'b0100);
        do_cmd(6, 2, 0, 0, 0);
        chk("sub_acc", 32'(acc), 32'h7F);
        chk("sub_flags", 32'(flags), 32'b1001);
        do_cmd(1, 0, 8'h00, 0, 0);
        chk("lda0_flags", 32'(flags), 32'b0011);
        do_cmd(7, 2, 0, 0, 0);
        chk("sbc_acc", 32'(acc), 32'hFF);
        chk("sbc_flags", 32'(flags), 32'b0100);

        // Illegal opcode leaves state alone; next command clears the error
        do_cmd(13, 1, 8'h77, 0, 0);
        chk("illegal_err", 32'(got_err), 32'd1);
        chk("illegal_acc", 32'(acc), 32'hFF);
        chk("illegal_flags", 32'(flags), 32'b0100);
        do_cmd(1, 0, 8'h11, 0, 0);
        chk("after_illegal_err", 32'(got_err), 32'd0);
        chk("after_illegal_acc", 32'(acc), 32'h11);

        // Back-pressure: response held while commands are offered
        do_cmd(4, 1, 0, 5, 1);
        chk("backpressure_acc", 32'(acc), 32'h12);

        // Reset in the middle of an STA r3 must not write r3
        do_cmd(1, 0, 8'h33, 0, 0);
        cmd_op    = 4'd3;
        cmd_rs    = 2'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("sta_in_exec", 32'(cmd_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midreset_ready", 32'(cmd_ready), 32'd0);
        chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_err", 32'(rsp_err), 32'd0);
        chk("midreset_acc", 32'(acc), 32'd0);
        chk("midreset_flags", 32'(flags), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_midreset", 32'(cmd_ready), 32'd1);
        do_cmd(1, 0, 8'h00, 0, 0);
        do_cmd(4, 3, 0, 0, 0);
        chk("r3_unwritten_acc", 32'(acc), 32'h00);
        chk("r3_unwritten_flags", 32'(flags), 32'b0010);

        // Random command stream against the model
        for (int k = 0; k < 250; k++) begin
            do_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_acc_alu_regfile
`default_nettype wire
